// File: rtl/uart_rx_fifo_if.sv
// CPU load-path port of the UART receiver: load strobe/address in, read data and
// pending-data interrupt out.
interface uart_rx_fifo_if;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        irq;

  modport master (output rd, addr, input rdata, irq);
  modport slave  (input rd, addr, output rdata, irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver with a 4-entry byte FIFO, read through the CPU
// MEM-stage load path at RXD (0x40000018) and STAT (0x4000001C).
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronised input
// START | start bit, checked again at mid-bit (8th tick) to reject glitches
// DATA  | 8 data bits sampled every 16 ticks, LSB first
// STOP  | stop bit sampled 16 ticks after bit 7; push, overrun or framing error
module uart_rx_fifo #(
  parameter int TICK_DIV   = 325,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  uart_rx_fifo_if.slave bus
);

  localparam logic [31:0] ADDR_RXD  = 32'h4000_0018;
  localparam logic [31:0] ADDR_STAT = 32'h4000_001C;
  localparam logic [15:0] TICK_LOAD = 16'(TICK_DIV - 1);
  localparam logic [2:0]  FULL_CNT  = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sync1, rx_s, rx_s_d;
  logic        fall;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [3:0]  sub_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  logic        restart, sub_clr, shift_en, stop_ok, stop_bad;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [1:0]  wptr, rptr;
  logic [2:0]  count;
  logic        ovr, ferr;
  logic        full, nonempty;
  logic        sel_rxd, sel_stat;
  logic        push, pop, ovr_set, stat_clr;

  // Synchroniser and falling-edge detect; reset high so the idle line gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= din;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  // Oversample timer: down-counter, tick on terminal count, reloaded at frame start.
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= 16'd0;
    end else if (restart || tick) begin
      tick_cnt <= TICK_LOAD;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    sub_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          restart = 1'b1;
          sub_clr = 1'b1;
        end
      end
      START: begin
        if (tick && sub_cnt == 4'd7) begin
          if (!rx_s) begin
            state_d = DATA;
            sub_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && sub_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick && sub_cnt == 4'd15) begin
          state_d  = IDLE;
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sub_cnt wraps modulo 16, so DATA/STOP need no explicit clear between bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_cnt <= 4'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (sub_clr) begin
        sub_cnt <= 4'd0;
      end else if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
      end
      if (sub_clr) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  end

  assign full     = (count == FULL_CNT);
  assign nonempty = (count != 3'd0);
  assign sel_rxd  = (bus.addr == ADDR_RXD);
  assign sel_stat = (bus.addr == ADDR_STAT);
  assign pop      = bus.rd & sel_rxd & nonempty;
  assign stat_clr = bus.rd & sel_stat;
  // A pop on the stop-sample edge frees the slot the new byte needs.
  assign push     = stop_ok & (~full | pop);
  assign ovr_set  = stop_ok & full & ~pop;

  // Storage is left unreset; reads are masked by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      ovr  <= (ovr  & ~stat_clr) | ovr_set;
      ferr <= (ferr & ~stat_clr) | stop_bad;
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (sel_rxd && nonempty) begin
      bus.rdata = {24'h0, mem[rptr]};
    end else if (sel_stat) begin
      bus.rdata = {25'h0, count, ferr, ovr, full, nonempty};
    end
  end

  assign bus.irq = nonempty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at TICK_DIV=4 (one bit = 64 clocks); frames are
// driven on falling clock edges and outputs are checked away from the rising edge.
module tb_uart_rx_fifo;

  localparam logic [31:0] RXD  = 32'h4000_0018;
  localparam logic [31:0] STAT = 32'h4000_001C;

  logic clk = 1'b0;
  logic reset;
  logic din;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.TICK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit slot 0 = start, 1..8 = data LSB first, 9 = stop, later = idle.
  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return stop;
    return 1'b1;
  endfunction

  // Drives negedge slots [from, to) of a frame; the stop bit is sampled on the
  // rising edge right after slot 610 begins.
  task automatic frame_seg(input logic [7:0] d, input logic stop, input int from, input int to);
    for (int i = from; i < to; i++) begin
      din = frame_bit(d, stop, i / 64);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    frame_seg(d, stop, 0, 640);
    din = 1'b1;
  endtask

  task automatic bus_peek(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a;
    bus.rd   = 1'b0;
    #1 v = bus.rdata;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a;
    bus.rd   = 1'b1;
    #1 v = bus.rdata;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_stat got %h want %h", v, 32'h0); end
    bus_peek(RXD, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_rxd got %h want %h", v, 32'h0); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_single;
    logic [31:0] v;
    frame_seg(8'h5A, 1'b1, 0, 610);
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_early got %b want 0", bus.irq); end
    frame_seg(8'h5A, 1'b1, 610, 611);
    n_checks++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL single_irq_rise got %b want 1", bus.irq); end
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h11) begin n_fail++; $display("FAIL single_stat got %h want %h", v, 32'h11); end
    bus_peek(RXD, v);
    n_checks++;
    if (v !== 32'h5A) begin n_fail++; $display("FAIL single_rxd got %h want %h", v, 32'h5A); end
    frame_seg(8'h5A, 1'b1, 611, 640);
    bus_read(RXD, v);
    n_checks++;
    if (v !== 32'h5A) begin n_fail++; $display("FAIL single_pop got %h want %h", v, 32'h5A); end
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL single_stat_after got %h want %h", v, 32'h0); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_fall got %b want 0", bus.irq); end
  endtask

  task automatic test_overrun;
    logic [31:0] v;
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h47) begin n_fail++; $display("FAIL ovr_stat got %h want %h", v, 32'h47); end
    for (int i = 0; i < 4; i++) begin
      bus_read(RXD, v);
      n_checks++;
      if (v !== 32'(i + 1)) begin n_fail++; $display("FAIL ovr_pop%0d got %h want %h", i, v, 32'(i + 1)); end
    end
    bus_read(STAT, v);
    n_checks++;
    if (v !== 32'h04) begin n_fail++; $display("FAIL ovr_stat_clr got %h want %h", v, 32'h04); end
    bus_read(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL ovr_stat_after got %h want %h", v, 32'h00); end
  endtask

  task automatic test_framing;
    logic [31:0] v;
    send(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h08) begin n_fail++; $display("FAIL ferr_stat got %h want %h", v, 32'h08); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL ferr_irq got %b want 0", bus.irq); end
    bus_read(STAT, v);
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL ferr_clear got %h want %h", v, 32'h00); end
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    din = 1'b0;
    repeat (8) @(negedge clk);
    din = 1'b1;
    repeat (100) @(negedge clk);
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL glitch_stat got %h want %h", v, 32'h00); end
    send(8'hC3, 1'b1);
    bus_read(RXD, v);
    n_checks++;
    if (v !== 32'hC3) begin n_fail++; $display("FAIL glitch_next got %h want %h", v, 32'hC3); end
  endtask

  task automatic test_push_pop_full;
    logic [31:0] v;
    for (int b = 8'h61; b <= 8'h64; b++) send(8'(b), 1'b1);
    frame_seg(8'h66, 1'b1, 0, 610);
    bus.addr = RXD;
    bus.rd   = 1'b1;
    #1 v = bus.rdata;
    n_checks++;
    if (v !== 32'h61) begin n_fail++; $display("FAIL pp_head got %h want %h", v, 32'h61); end
    frame_seg(8'h66, 1'b1, 610, 611);
    bus.rd = 1'b0;
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h43) begin n_fail++; $display("FAIL pp_stat got %h want %h", v, 32'h43); end
    frame_seg(8'h66, 1'b1, 611, 640);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 3) ? 8'h66 : 8'(8'h62 + i);
      bus_read(RXD, v);
      n_checks++;
      if (v !== {24'h0, exp_b}) begin n_fail++; $display("FAIL pp_pop%0d got %h want %h", i, v, exp_b); end
    end
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL pp_stat_after got %h want %h", v, 32'h00); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] v;
    send(8'h11, 1'b1);
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h11) begin n_fail++; $display("FAIL rst_pre_stat got %h want %h", v, 32'h11); end
    frame_seg(8'h99, 1'b1, 0, 280);
    reset = 1'b1;
    din   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL rst_stat got %h want %h", v, 32'h00); end
    bus_peek(RXD, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL rst_rxd got %h want %h", v, 32'h00); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", bus.irq); end
    repeat (50) @(negedge clk);
    send(8'h3C, 1'b1);
    bus_read(RXD, v);
    n_checks++;
    if (v !== 32'h3C) begin n_fail++; $display("FAIL rst_next got %h want %h", v, 32'h3C); end
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL rst_next_stat got %h want %h", v, 32'h00); end
  endtask

  task automatic test_decode;
    logic [31:0] v;
    send(8'h5C, 1'b1);
    bus_read(32'h4000_0020, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL dec_0020 got %h want %h", v, 32'h0); end
    bus_read(32'h4000_001A, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL dec_001a got %h want %h", v, 32'h0); end
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h11) begin n_fail++; $display("FAIL dec_nopop got %h want %h", v, 32'h11); end
    bus_read(RXD, v);
    n_checks++;
    if (v !== 32'h5C) begin n_fail++; $display("FAIL dec_rxd got %h want %h", v, 32'h5C); end
  endtask

  task automatic test_wrap;
    logic [31:0] v;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'(8'h10 + i);
      send(b, 1'b1);
      bus_read(RXD, v);
      n_checks++;
      if (v !== {24'h0, b}) begin n_fail++; $display("FAIL wrap%0d got %h want %h", i, v, b); end
    end
    bus_peek(STAT, v);
    n_checks++;
    if (v !== 32'h00) begin n_fail++; $display("FAIL wrap_stat got %h want %h", v, 32'h00); end
  endtask

  initial begin
    din      = 1'b1;
    reset    = 1'b1;
    bus.rd   = 1'b0;
    bus.addr = 32'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overrun();
    test_framing();
    test_glitch();
    test_push_pop_full();
    test_reset_midframe();
    test_decode();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
